// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a two-state FSM: one requester is granted and holds
// the grant until it drops its request; the search pointer then moves past it.
module rr_arbiter #(
  parameter int IDX_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [(1<<IDX_WIDTH)-1:0]   req,
  output logic [(1<<IDX_WIDTH)-1:0]   gnt,
  output logic [IDX_WIDTH-1:0]        gnt_idx,
  output logic                        gnt_valid
);

  localparam int N = 1 << IDX_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] ptr, ptr_nxt;
  logic [IDX_WIDTH-1:0] idx_nxt;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_found;
  logic [N-1:0]         gnt_nxt;

  // Rotating search: first set request at or above ptr, wrapping through N-1 to 0.
  // Index arithmetic is IDX_WIDTH bits wide, so the wrap comes for free.
  always_comb begin
    logic [IDX_WIDTH-1:0] cand;
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_WIDTH'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    case (state)
      IDLE: begin
        if (en && win_found) begin
          state_nxt = BUSY;
          idx_nxt   = win_idx;
        end
      end
      BUSY: begin
        // Only the holder's own request matters; en cannot revoke the grant.
        if (!req[gnt_idx]) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + IDX_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    gnt_nxt = '0;
    if (state_nxt == BUSY) begin
      gnt_nxt[idx_nxt] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= (state_nxt == BUSY);
      gnt       <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=4): stimulus pushes expected outputs from a
// behavioural owner/pointer model; a monitor pops and compares after each edge.
module tb_rr_arbiter;

  localparam int IDX_WIDTH = 2;
  localparam int N = 1 << IDX_WIDTH;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic                 gnt_valid;

  rr_arbiter #(.IDX_WIDTH(IDX_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                 valid;
    logic [IDX_WIDTH-1:0] idx;
    logic [N-1:0]         gnt;
    string                tag;
  } exp_t;

  exp_t  sb_q[$];
  int    grant_log[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  // Reference model: who owns the grant (-1 = nobody), where the next search
  // starts, and the last granted index (gnt_idx holds it while idle).
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
  endtask

  task automatic model_step(input logic e, input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (e && r != '0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          break;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.valid = (m_owner >= 0);
    e.idx   = IDX_WIDTH'(m_last);
    e.gnt   = e.valid ? N'(1 << m_last) : '0;
    e.tag   = phase;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic e, input logic [N-1:0] r);
    @(negedge clk);
    en  = e;
    req = r;
    model_step(e, r);
    push_expected();
  endtask

  // Pulse reset between edges, check the immediate clear, then apply new inputs.
  task automatic reset_pulse(input logic e, input logic [N-1:0] r);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({phase, " async gnt"},       32'(gnt),       32'h0);
    check({phase, " async gnt_valid"}, 32'(gnt_valid), 32'h0);
    check({phase, " async gnt_idx"},   32'(gnt_idx),   32'h0);
    en  = e;
    req = r;
    #1 rst_n = 1'b1;
    model_reset();
    model_step(e, r);
    push_expected();
  endtask

  // Monitor: compare against the scoreboard and check the one-hot invariant.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, " gnt_valid"}, 32'(gnt_valid), 32'(e.valid));
        check({e.tag, " gnt_idx"},   32'(gnt_idx),   32'(e.idx));
        check({e.tag, " gnt"},       32'(gnt),       32'(e.gnt));
      end
      check({phase, " invariant"}, 32'(gnt), gnt_valid ? 32'(1 << gnt_idx) : 32'h0);
      if (gnt_valid && !prev_valid) grant_log.push_back(int'(gnt_idx));
      prev_valid = gnt_valid;
    end
  end

  initial begin : stimulus
    int hold;
    int want[5];
    logic [N-1:0] r;
    logic         e;
    want = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    model_reset();
    #1;
    check("por gnt",       32'(gnt),       32'h0);
    check("por gnt_valid", 32'(gnt_valid), 32'h0);
    check("por gnt_idx",   32'(gnt_idx),   32'h0);

    // Release with a pending request: grant on the first edge, idx 1.
    phase = "basic";
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 4'b0110;
    model_step(1'b1, 4'b0110);
    push_expected();
    @(posedge clk);
    #2;
    check("basic first grant", 32'({gnt_valid, gnt_idx, gnt}), 32'({1'b1, 2'd1, 4'b0010}));
    drive(1'b1, 4'b0110);
    drive(1'b1, 4'b1110);
    drive(1'b1, 4'b0000);

    // Every requester held; each grantee drops its bit after two granted cycles.
    phase = "rotate";
    grant_log.delete();
    reset_pulse(1'b1, 4'b1111);
    hold = 0;
    for (int c = 0; c < 40 && grant_log.size() < 5; c++) begin
      if (m_owner >= 0) hold++;
      else hold = 0;
      r = 4'b1111;
      if (m_owner >= 0 && hold >= 2) r[m_owner] = 1'b0;
      drive(1'b1, r);
    end
    @(posedge clk);
    #2;
    check("rotate grant count", 32'(grant_log.size() >= 5), 32'h1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check($sformatf("rotate order %0d", i), 32'(grant_log[i]), 32'(want[i]));
    end

    // Grant idx 3, release, then 1001: pointer wraps to 0.
    phase = "wrap";
    reset_pulse(1'b1, 4'b1000);
    drive(1'b1, 4'b1000);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1001);
    @(posedge clk);
    #2;
    check("wrap grant", 32'({gnt_valid, gnt_idx, gnt}), 32'({1'b1, 2'd0, 4'b0001}));
    drive(1'b1, 4'b0000);

    // en low blocks new grants but never revokes a held one.
    phase = "enable";
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0100);
    @(posedge clk);
    #2;
    check("enable grant", 32'({gnt_valid, gnt}), 32'({1'b1, 4'b0100}));
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0100);
    drive(1'b0, 4'b0000);

    // Reset mid-grant on idx 2; next search restarts at 0 and finds 2.
    phase = "midreset";
    drive(1'b1, 4'b0100);
    drive(1'b1, 4'b0100);
    reset_pulse(1'b1, 4'b1100);
    @(posedge clk);
    #2;
    check("midreset regrant", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 2'd2}));
    drive(1'b1, 4'b0000);

    // Random traffic; the holder keeps its request most of the time.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      e = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 49) == 0) reset_pulse(e, r);
      else drive(e, r);
    end

    phase = "drain";
    drive(1'b0, 4'b0000);
    @(posedge clk);
    #3;
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter IDX_WIDTH, default 2, SHALL set the grant index width; localparam N = 1 << IDX_WIDTH SHALL be the number of requesters.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port en, input, 1, SHALL enable new grants when high.
REQ-005 Port req, input, N, SHALL carry one request bit per requester, bit k for requester k.
REQ-006 Port gnt, output, N, SHALL be the registered one-hot grant vector, decoded from gnt_idx.
REQ-007 Port gnt_idx, output, IDX_WIDTH, SHALL be the registered binary index of the granted requester.
REQ-008 Port gnt_valid, output, 1, SHALL be high while a grant is held.

Function
REQ-009 The FSM SHALL have exactly two states, IDLE and BUSY, plus an internal IDX_WIDTH-bit priority pointer ptr.
REQ-010 IDLE to BUSY: when en=1 and req!=0 at a clk edge, the block SHALL latch the winner, go to BUSY and set gnt_valid=1 on that edge.
REQ-011 Winner selection SHALL be the first set req bit searched from index ptr upward, wrapping from N-1 to 0.
REQ-012 Request-to-grant latency SHALL be exactly 1 cycle: req sampled at edge t, gnt visible after edge t.
REQ-013 In IDLE with en=0 or req=0, outputs SHALL stay gnt=0, gnt_valid=0, and gnt_idx SHALL keep its last value.
REQ-014 In BUSY, gnt, gnt_idx and gnt_valid SHALL hold while req[gnt_idx]=1; all other req bits SHALL be ignored.
REQ-015 BUSY to IDLE: when req[gnt_idx]=0 at a clk edge, the block SHALL set gnt=0, gnt_valid=0 and ptr = (gnt_idx+1) mod N, then enter IDLE.
REQ-016 There SHALL be a minimum one-cycle gap (gnt_valid=0) between consecutive grants.
REQ-017 Deasserting en during BUSY SHALL NOT revoke the current grant; it only blocks the next one.
REQ-018 Invariant: gnt SHALL equal 1<<gnt_idx when gnt_valid=1, gnt SHALL be all-zero when gnt_valid=0, and gnt SHALL never have more than one bit set.
REQ-019 ptr increment SHALL wrap modulo N with no overflow state; N-1 plus 1 SHALL give 0.
REQ-020 Fairness: a requester holding req continuously with en=1 SHALL be granted within N grants.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, ptr=0, gnt=0, gnt_idx=0 and gnt_valid=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant at once, and the first grant after release SHALL search from index 0.
REQ-023 rst_n released with en=1 and req!=0 SHALL produce a grant on the first clk edge after release.

Verification (N=4)
REQ-024 Reset then en=1, req=4'b0110 -> one cycle later gnt=4'b0010, gnt_idx=1, gnt_valid=1; grant held while req[1]=1.
REQ-025 req=4'b1111 held, each grantee drops its bit 2 cycles after grant and then re-raises it -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-026 Grant to idx 3, release, then req=4'b1001 -> gnt_idx=0 (pointer wrap) and gnt=4'b0001.
REQ-027 en=0, req=4'b0100 for 5 cycles -> gnt_valid stays 0; en=1 -> gnt=4'b0100 next cycle; en dropped while BUSY -> grant held until req[2] falls.
REQ-028 Grant active on idx 2, rst_n pulsed low between edges -> gnt=0 and gnt_valid=0 immediately; after release with req=4'b1100 -> gnt_idx=2 (search from 0).
REQ-029 Every cycle of every scenario -> the one-hot/valid invariant of REQ-018 SHALL be checked.
